// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl -- 640x480@60 VGA timing generator with a run/stop sequencer.
//
// Purpose:
//   Produces the horizontal/vertical pixel counters that feed the colorbar /
//   pattern generator, plus active-low hsync/vsync, the active-video window
//   (vidon) and a one-clock frame_start pulse. A stop request (en low) always
//   lets the current frame finish before the counters park at (0,0), so the
//   monitor never sees a truncated frame.
//
// Ports:
//   clk          in   1   system clock
//   clr          in   1   asynchronous active-high reset
//   en           in   1   run request, level-sensitive
//   hc           out  10  horizontal count, registered
//   vc           out  10  vertical count, registered
//   hsync        out  1   active-low horizontal sync
//   vsync        out  1   active-low vertical sync
//   vidon        out  1   high inside the active video window
//   pix_tick     out  1   one-clk strobe; hc/vc advance on it
//   frame_start  out  1   one-clk pulse when counters enter (0,0) while running
//   busy         out  1   high in RUN or DRAIN
//   frame_cnt    out  16  frames started (only with VGA_FRAME_CNT_EN)
//
// Configuration macro:
//   VGA_FRAME_CNT_EN  adds the frame_cnt output and its counter.

module vga_sync_ctrl #(
  parameter int unsigned HPIXELS = 800,
  parameter int unsigned VLINES  = 521,
  parameter int unsigned HPULSE  = 96,
  parameter int unsigned VPULSE  = 2,
  parameter int unsigned HBP     = 144,
  parameter int unsigned HFP     = 784,
  parameter int unsigned VBP     = 31,
  parameter int unsigned VFP     = 511,
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  output logic        hsync,
  output logic        vsync,
  output logic        vidon,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        busy
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [9:0] LP_HLAST    = 10'(HPIXELS - 1);
  localparam logic [9:0] LP_VLAST    = 10'(VLINES - 1);
  localparam logic [9:0] LP_HPULSE   = 10'(HPULSE);
  localparam logic [9:0] LP_VPULSE   = 10'(VPULSE);
  localparam logic [9:0] LP_HBP      = 10'(HBP);
  localparam logic [9:0] LP_HFP      = 10'(HFP);
  localparam logic [9:0] LP_VBP      = 10'(VBP);
  localparam logic [9:0] LP_VFP      = 10'(VFP);
  localparam logic [3:0] LP_DIV_LAST = 4'(CLK_DIV - 1);

`ifndef SYNTHESIS
  if (!(HPULSE < HBP && HBP < HFP && HFP <= HPIXELS &&
        VPULSE < VBP && VBP < VFP && VFP <= VLINES &&
        HPIXELS <= 1024 && VLINES <= 1024 &&
        CLK_DIV >= 1 && CLK_DIV <= 16)) begin : g_param_check
    $error("vga_sync_ctrl: illegal timing parameters");
  end
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t     r_state;
  logic [3:0] r_div;
  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       r_frame_start;

  logic w_active;
  logic w_tick;
  logic w_hwrap;
  logic w_fwrap;
  logic w_fs_set;

  assign w_active = (r_state != ST_IDLE);
  // Divider is held at 0 in IDLE, so the strobe is gated by the state as well.
  assign w_tick   = w_active && (r_div == LP_DIV_LAST);
  assign w_hwrap  = (r_hc == LP_HLAST);
  assign w_fwrap  = w_tick && w_hwrap && (r_vc == LP_VLAST);

  // A new frame begins either on the start from IDLE or on the wrap tick while
  // the sequencer is (or is returning to) RUN. A DRAIN wrap parks silently.
  always_comb begin
    w_fs_set = 1'b0;
    case (r_state)
      ST_IDLE:  w_fs_set = en;
      ST_RUN:   w_fs_set = w_fwrap;
      ST_DRAIN: w_fs_set = en && w_fwrap;
      default:  w_fs_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state       <= ST_IDLE;
      r_div         <= '0;
      r_hc          <= '0;
      r_vc          <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_fs_set;

      if (w_active) begin
        r_div <= (r_div == LP_DIV_LAST) ? '0 : r_div + 4'd1;
      end else begin
        r_div <= '0;
      end

      if (w_tick) begin
        if (w_hwrap) begin
          r_hc <= '0;
          r_vc <= (r_vc == LP_VLAST) ? '0 : r_vc + 10'd1;
        end else begin
          r_hc <= r_hc + 10'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (en) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // Dropping en on the wrap tick still commits to the new frame.
          if (!en) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Re-asserting en resumes the same frame without touching counters.
          if (en)           r_state <= ST_RUN;
          else if (w_fwrap) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Advances together with the frame_start register so the new value is
  // visible during the frame_start cycle; it holds through IDLE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_frame_cnt <= '0;
    end else if (w_fs_set) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  always_comb begin
    hsync = !(w_active && (r_hc < LP_HPULSE));
    vsync = !(w_active && (r_vc < LP_VPULSE));
    vidon = w_active &&
            (r_hc >= LP_HBP) && (r_hc < LP_HFP) &&
            (r_vc >= LP_VBP) && (r_vc < LP_VFP);
  end

  assign hc          = r_hc;
  assign vc          = r_vc;
  assign pix_tick    = w_tick;
  assign frame_start = r_frame_start;
  assign busy        = w_active;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb_vga_sync_ctrl -- directed bench for vga_sync_ctrl using a reduced frame
// geometry (20 x 12, 240 ticks per frame) so whole frames fit in a short run.
// DUT a runs with CLK_DIV=1, DUT b with CLK_DIV=4 (960 clks per frame).
// All stimulus and sampling happens on the falling clock edge; pos counts
// falling edges since the latest IDLE->RUN transition edge.

module tb_vga_sync_ctrl;

  logic       clk;
  logic       clr;
  logic       en;
  logic       en_b;
  logic [9:0] hc, vc, hc_b, vc_b;
  logic       hsync, vsync, vidon, pix_tick, frame_start, busy;
  logic       hsync_b, vsync_b, vidon_b, pix_tick_b, frame_start_b, busy_b;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt, frame_cnt_b;
`endif

  int total = 0;
  int bad   = 0;
  int pos   = 0;

  vga_sync_ctrl #(
    .HPIXELS(20), .VLINES(12), .HPULSE(3), .VPULSE(2),
    .HBP(5), .HFP(18), .VBP(3), .VFP(11), .CLK_DIV(1)
  ) u_dut_a (
    .clk(clk), .clr(clr), .en(en), .hc(hc), .vc(vc),
    .hsync(hsync), .vsync(vsync), .vidon(vidon), .pix_tick(pix_tick),
    .frame_start(frame_start), .busy(busy)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  vga_sync_ctrl #(
    .HPIXELS(20), .VLINES(12), .HPULSE(3), .VPULSE(2),
    .HBP(5), .HFP(18), .VBP(3), .VFP(11), .CLK_DIV(4)
  ) u_dut_b (
    .clk(clk), .clr(clr), .en(en_b), .hc(hc_b), .vc(vc_b),
    .hsync(hsync_b), .vsync(vsync_b), .vidon(vidon_b), .pix_tick(pix_tick_b),
    .frame_start(frame_start_b), .busy(busy_b)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int target);
    repeat (target - pos) @(negedge clk);
    pos = target;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; en_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hc", 32'(hc), 0);
    chk("rst_vc", 32'(vc), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_vidon", 32'(vidon), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(pix_tick), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
`ifdef VGA_FRAME_CNT_EN
    chk("rst_fcnt", 32'(frame_cnt), 0);
`endif
    clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_hsync", 32'(hsync), 1);

    // Start both DUTs together.
    en = 1'b1; en_b = 1'b1;
    pos = -1; goto(0);
    chk("start_fs", 32'(frame_start), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_hcvc", 32'({vc, hc}), 0);
    chk("start_tick", 32'(pix_tick), 1);
    chk("start_hsync", 32'(hsync), 0);
    chk("start_vsync", 32'(vsync), 0);
    chk("start_vidon", 32'(vidon), 0);
    chk("start_fs_b", 32'(frame_start_b), 1);
    chk("start_tick_b", 32'(pix_tick_b), 0);
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_1", 32'(frame_cnt), 1);
`endif
    goto(1);
    chk("fs_one_clk", 32'(frame_start), 0);
    chk("hc_1", 32'(hc), 1);
    goto(2);
    chk("hsync_hc2", 32'(hsync), 0);
    goto(3);
    chk("hsync_hc3", 32'(hsync), 1);
    chk("tick_b_div3", 32'(pix_tick_b), 1);
    chk("hc_b_pos3", 32'(hc_b), 0);
    goto(4);
    chk("hc_b_pos4", 32'(hc_b), 1);
    chk("tick_b_pos4", 32'(pix_tick_b), 0);
    goto(39);
    chk("line_end", 32'({vc, hc}), {22'd0, 10'd1, 10'd19});
    chk("vsync_vc1", 32'(vsync), 0);
    goto(40);
    chk("vc2_wrap", 32'({vc, hc}), {22'd0, 10'd2, 10'd0});
    chk("vsync_vc2", 32'(vsync), 1);
    goto(64);
    chk("pre_active", 32'({vidon, vc, hc}), {11'd0, 1'b0, 10'd3, 10'd4});
    goto(65);
    chk("first_active", 32'(vidon), 1);
    goto(80);
    chk("b_line", 32'({vc_b, hc_b}), {22'd0, 10'd1, 10'd0});
    goto(217);
    chk("last_active", 32'({vidon, vc, hc}), {11'd0, 1'b1, 10'd10, 10'd17});
    goto(218);
    chk("hfp_inactive", 32'(vidon), 0);
    goto(239);
    chk("frame_end", 32'({frame_start, vc, hc}), {11'd0, 1'b0, 10'd11, 10'd19});
    chk("vfp_inactive", 32'(vidon), 0);
    goto(240);
    chk("frame2_fs", 32'({frame_start, vc, hc}), {11'd0, 1'b1, 20'd0});
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_2", 32'(frame_cnt), 2);
`endif

    // Stop mid-frame: must drain to the end of the frame.
    goto(350);
    chk("stop_point", 32'({vc, hc}), {22'd0, 10'd5, 10'd10});
    en = 1'b0;
    goto(351);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_hc", 32'(hc), 11);
    goto(479);
    chk("drain_end", 32'({busy, vc, hc}), {11'd0, 1'b1, 10'd11, 10'd19});
    goto(480);
    chk("parked_busy", 32'(busy), 0);
    chk("parked_fs", 32'(frame_start), 0);
    chk("parked_hcvc", 32'({vc, hc}), 0);
    chk("parked_sync", 32'({hsync, vsync, vidon, pix_tick}), 32'b1100);
    goto(485);
    chk("parked_hold", 32'({busy, hc}), 0);
    goto(959);
    chk("b_frame_end", 32'({frame_start_b, vc_b, hc_b}), {11'd0, 1'b0, 10'd11, 10'd19});
    goto(960);
    chk("b_frame2_fs", 32'({frame_start_b, vc_b, hc_b}), {11'd0, 1'b1, 20'd0});
    chk("a_still_idle", 32'(busy), 0);

    // Restart, then stop and resume within one frame.
    en = 1'b1;
    pos = -1; goto(0);
    chk("restart_fs", 32'({busy, frame_start, hc}), {20'd0, 1'b1, 1'b1, 10'd0});
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_3", 32'(frame_cnt), 3);
`endif
    goto(100);
    chk("pause_point", 32'({vc, hc}), {22'd0, 10'd5, 10'd0});
    en = 1'b0;
    goto(101);
    chk("pause_drain", 32'({busy, hc}), {21'd0, 1'b1, 10'd1});
    goto(160);
    en = 1'b1;
    goto(161);
    chk("resume_cont", 32'({busy, vc, hc}), {11'd0, 1'b1, 10'd8, 10'd1});
    goto(239);
    chk("resume_no_fs", 32'({busy, frame_start}), 32'b10);
    goto(240);
    chk("resume_wrap_fs", 32'({frame_start, vc, hc}), {11'd0, 1'b1, 20'd0});
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_4", 32'(frame_cnt), 4);
`endif

    // en drops exactly on the wrap tick: the new frame is still fully drawn.
    goto(479);
    en = 1'b0;
    goto(480);
    chk("wrapstop_fs", 32'({busy, frame_start, vc, hc}), {10'd0, 2'b11, 20'd0});
    goto(719);
    chk("wrapstop_full", 32'({busy, vc, hc}), {11'd0, 1'b1, 10'd11, 10'd19});
    goto(720);
    chk("wrapstop_idle", 32'({busy, frame_start}), 0);

    // Asynchronous clear mid-frame with en held high.
    en = 1'b1;
    pos = -1; goto(0);
    chk("pre_clr_fs", 32'(frame_start), 1);
    goto(130);
    chk("clr_point", 32'({vc, hc}), {22'd0, 10'd6, 10'd10});
    clr = 1'b1;
    #1;
    chk("clr_async", 32'({busy, vc, hc}), 0);
    @(negedge clk);
    chk("clr_outs", 32'({hsync, vsync, vidon, pix_tick, frame_start}), 32'b11000);
    chk("clr_b", 32'({busy_b, vc_b, hc_b}), 0);
`ifdef VGA_FRAME_CNT_EN
    chk("clr_fcnt", 32'(frame_cnt), 0);
`endif
    clr = 1'b0;
    pos = -1; goto(0);
    chk("post_clr_fs", 32'({busy, frame_start, vc, hc}), {10'd0, 2'b11, 20'd0});
    chk("post_clr_fs_b", 32'(frame_start_b), 1);
    goto(1);
    chk("post_clr_hc", 32'(hc), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
